// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the CPU port, the SPI loader port and the RAM macro port of mem_arbiter.
// The arbiter connects through the slave modport; the surrounding logic (or a bench) uses master.
interface mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_hold;

  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_hold,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_hold,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU and the SPI loader.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is loader priority with a burst guard.
module mem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

  state_t     state;
  owner_t     owner;
  logic [1:0] wait_cnt;
  logic       grant_ldr;
  logic       grant_cpu;

`ifdef MEM_ARB_RR_EN
  logic last_cpu;

  // On contention the requester that did not win last time gets the RAM.
  always_comb begin
    grant_ldr = bus.ldr_req && (!bus.cpu_req || last_cpu);
    grant_cpu = bus.cpu_req && !grant_ldr;
  end
`else
  logic [3:0] burst_cnt;
  logic       starve_guard;

  always_comb begin
    starve_guard = bus.cpu_req && (burst_cnt >= 4'(MAX_BURST));
    grant_ldr    = bus.ldr_req && !starve_guard;
    grant_cpu    = bus.cpu_req && !grant_ldr;
  end
`endif

  assign bus.cpu_hold = bus.cpu_req && !(state == ACK && owner == OWN_CPU);

  // mem_addr/mem_wdata double as the latched copy of the granted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      wait_cnt      <= 2'd0;
      bus.cpu_ack   <= 1'b0;
      bus.ldr_ack   <= 1'b0;
      bus.cpu_rdata <= {DW{1'b0}};
      bus.ldr_rdata <= {DW{1'b0}};
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
`ifdef MEM_ARB_RR_EN
      last_cpu      <= 1'b1;
`else
      burst_cnt     <= 4'd0;
`endif
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.ldr_ack <= 1'b0;
      bus.mem_en  <= 1'b0;
      bus.mem_we  <= 1'b0;
`ifndef MEM_ARB_RR_EN
      if (!bus.cpu_req) burst_cnt <= 4'd0;
`endif
      case (state)
        IDLE: begin
          if (grant_ldr) begin
            owner         <= OWN_LDR;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.ldr_we;
            bus.mem_addr  <= bus.ldr_addr;
            bus.mem_wdata <= bus.ldr_wdata;
            state         <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_cpu      <= 1'b0;
`else
            if (bus.cpu_req) burst_cnt <= burst_cnt + 4'd1;
`endif
          end else if (grant_cpu) begin
            owner         <= OWN_CPU;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.cpu_we;
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_wdata <= bus.cpu_wdata;
            state         <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_cpu      <= 1'b1;
`else
            burst_cnt     <= 4'd0;
`endif
          end
        end
        ISSUE: begin
          if (bus.mem_we) begin
            if (owner == OWN_CPU) bus.cpu_ack <= 1'b1;
            else                  bus.ldr_ack <= 1'b1;
            state <= ACK;
          end else begin
            wait_cnt <= 2'(RD_LAT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (owner == OWN_CPU) begin
              bus.cpu_rdata <= bus.mem_rdata;
              bus.cpu_ack   <= 1'b1;
            end else begin
              bus.ldr_rdata <= bus.mem_rdata;
              bus.ldr_ack   <= 1'b1;
            end
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ACK: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3.
// Expected acks go into per-instance scoreboards and are checked for owner, cycle and read data.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  typedef struct {
    bit          cpu;
    bit          rd;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb1[$];
  exp_t sb3[$];

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_BURST(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_BURST(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave)
  );

  // RAM model for the RD_LAT=1 instance; read data is poisoned outside its valid cycle.
  logic [DW-1:0] ram1 [0:4095];
  logic          rd1_v = 1'b0;
  logic [DW-1:0] rd1_d;

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) ram1[b1.mem_addr] <= b1.mem_wdata;
    rd1_v <= b1.mem_en && !b1.mem_we;
    rd1_d <= ram1[b1.mem_addr];
  end
  assign b1.mem_rdata = rd1_v ? rd1_d : 16'hDEAD;

  // Read-only model for the RD_LAT=3 instance.
  function automatic logic [15:0] rom3(input logic [11:0] a);
    if (a == 12'h7FF)      return 16'hA5C3;
    else if (a == 12'h020) return 16'h1234;
    else                   return {4'h0, a};
  endfunction

  logic [2:0]    v3 = 3'b000;
  logic [DW-1:0] d3 [3];

  always @(posedge clk) begin
    v3    <= {v3[1:0], b3.mem_en && !b3.mem_we};
    d3[0] <= rom3(b3.mem_addr);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign b3.mem_rdata = v3[2] ? d3[2] : 16'hDEAD;

  // Scoreboard checkers, one per instance.
  always @(negedge clk) begin
    exp_t e;
    if (b1.cpu_ack || b1.ldr_ack) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("[TB] FAIL ack1_unexpected cpu_ack=%0b ldr_ack=%0b cyc=%0d expected no ack", b1.cpu_ack, b1.ldr_ack, ncyc);
      end else begin
        e = sb1.pop_front();
        if ({b1.cpu_ack, b1.ldr_ack} !== {e.cpu, !e.cpu} || ncyc != e.due ||
            (e.rd && ((e.cpu ? b1.cpu_rdata : b1.ldr_rdata) !== e.data))) begin
          errors++;
          $display("[TB] FAIL ack1 cpu_ack=%0b ldr_ack=%0b cyc=%0d cpu_rdata=%h ldr_rdata=%h expected cpu=%0b cyc=%0d rd=%0b data=%h",
                   b1.cpu_ack, b1.ldr_ack, ncyc, b1.cpu_rdata, b1.ldr_rdata, e.cpu, e.due, e.rd, e.data);
        end
      end
    end else if (sb1.size() != 0 && ncyc > sb1[0].due) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack1_missing cyc=%0d no ack expected cpu=%0b due=%0d", ncyc, sb1[0].cpu, sb1[0].due);
      void'(sb1.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b3.cpu_ack || b3.ldr_ack) begin
      checks++;
      if (sb3.size() == 0) begin
        errors++;
        $display("[TB] FAIL ack3_unexpected cpu_ack=%0b ldr_ack=%0b cyc=%0d expected no ack", b3.cpu_ack, b3.ldr_ack, ncyc);
      end else begin
        e = sb3.pop_front();
        if ({b3.cpu_ack, b3.ldr_ack} !== {e.cpu, !e.cpu} || ncyc != e.due ||
            (e.rd && ((e.cpu ? b3.cpu_rdata : b3.ldr_rdata) !== e.data))) begin
          errors++;
          $display("[TB] FAIL ack3 cpu_ack=%0b ldr_ack=%0b cyc=%0d cpu_rdata=%h ldr_rdata=%h expected cpu=%0b cyc=%0d rd=%0b data=%h",
                   b3.cpu_ack, b3.ldr_ack, ncyc, b3.cpu_rdata, b3.ldr_rdata, e.cpu, e.due, e.rd, e.data);
        end
      end
    end else if (sb3.size() != 0 && ncyc > sb3[0].due) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack3_missing cyc=%0d no ack expected cpu=%0b due=%0d", ncyc, sb3[0].cpu, sb3[0].due);
      void'(sb3.pop_front());
    end
  end

  task automatic test_reset();
    logic [64:0] o1, o3;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      o1 = {b1.mem_en, b1.mem_we, b1.cpu_ack, b1.ldr_ack, b1.cpu_hold,
            b1.mem_addr, b1.mem_wdata, b1.cpu_rdata, b1.ldr_rdata};
      o3 = {b3.mem_en, b3.mem_we, b3.cpu_ack, b3.ldr_ack, b3.cpu_hold,
            b3.mem_addr, b3.mem_wdata, b3.cpu_rdata, b3.ldr_rdata};
      checks++;
      if (o1 !== 65'd0 || o3 !== 65'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs step=%0d dut1=%h dut3=%h expected 0", i, o1, o3);
      end
    end
  endtask

  task automatic test_cpu_write_read();
    exp_t e;
    int   n;
    @(negedge clk);
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 12'h020; b1.cpu_wdata = 16'h7800;
    e.cpu = 1'b1; e.rd = 1'b0; e.data = 16'h0000; e.due = ncyc + 2; sb1.push_back(e);
    n = 0;
    while (b1.cpu_ack !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
      checks++;
      if (b1.cpu_hold !== !b1.cpu_ack) begin
        errors++;
        $display("[TB] FAIL cpu_hold_wr cpu_hold=%b expected %b", b1.cpu_hold, !b1.cpu_ack);
      end
    end
    checks++;
    if (b1.cpu_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cpu_wr_timeout cpu_ack=%b expected 1", b1.cpu_ack);
    end
    b1.cpu_req = 1'b0;

    @(negedge clk);
    checks++;
    if (b1.cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_hold_idle cpu_hold=%b expected 0", b1.cpu_hold);
    end
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 12'h020; b1.cpu_wdata = 16'hFFFF;
    e.cpu = 1'b1; e.rd = 1'b1; e.data = 16'h7800; e.due = ncyc + 3; sb1.push_back(e);
    n = 0;
    while (b1.cpu_ack !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
      checks++;
      if (b1.cpu_hold !== !b1.cpu_ack) begin
        errors++;
        $display("[TB] FAIL cpu_hold_rd cpu_hold=%b expected %b", b1.cpu_hold, !b1.cpu_ack);
      end
    end
    checks++;
    if (b1.cpu_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cpu_rd_timeout cpu_ack=%b expected 1", b1.cpu_ack);
    end
    b1.cpu_req = 1'b0;
  endtask

  task automatic test_loader_burst();
    exp_t e;
    int   n, k, t0;
    bit   cdone;
    @(negedge clk);
    t0 = ncyc; k = 0; n = 0; cdone = 1'b0;
    b1.ldr_req = 1'b1; b1.ldr_we = 1'b1; b1.ldr_addr = 12'h000; b1.ldr_wdata = 16'hC000;
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 12'h020;
    for (int i = 0; i < 8; i++) begin
      e.cpu = 1'b0; e.rd = 1'b0; e.data = 16'h0000; e.due = t0 + 2 + 3 * i; sb1.push_back(e);
    end
    e.cpu = 1'b1; e.rd = 1'b1; e.data = 16'h7800; e.due = t0 + 27; sb1.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.cpu = 1'b0; e.rd = 1'b0; e.data = 16'h0000; e.due = t0 + 30 + 3 * i; sb1.push_back(e);
    end
    while ((k < 16 || !cdone) && n < 120) begin
      @(negedge clk); n++;
      if (b1.cpu_req) begin
        checks++;
        if (b1.cpu_hold !== !b1.cpu_ack) begin
          errors++;
          $display("[TB] FAIL cpu_hold_burst cpu_hold=%b expected %b", b1.cpu_hold, !b1.cpu_ack);
        end
      end
      if (b1.ldr_ack) begin
        k++;
        if (k == 16) b1.ldr_req = 1'b0;
        else begin
          b1.ldr_addr  = 12'(k);
          b1.ldr_wdata = 16'hC000 + 16'(k);
        end
      end
      if (b1.cpu_ack) begin
        cdone = 1'b1;
        b1.cpu_req = 1'b0;
      end
    end
    checks++;
    if (k != 16 || !cdone) begin
      errors++;
      $display("[TB] FAIL burst_timeout ldr_acks=%0d cpu_done=%0b expected 16 and 1", k, cdone);
    end
    b1.ldr_req = 1'b0; b1.cpu_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ram1[i] !== 16'hC000 + 16'(i)) begin
        errors++;
        $display("[TB] FAIL burst_ram addr=%0d got=%h expected %h", i, ram1[i], 16'hC000 + 16'(i));
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   n, kl, kc, t0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t0 = ncyc; kl = 0; kc = 0; n = 0;
    b1.ldr_req = 1'b1; b1.ldr_we = 1'b1; b1.ldr_addr = 12'h100; b1.ldr_wdata = 16'hB000;
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 12'h200; b1.cpu_wdata = 16'hD000;
    for (int i = 0; i < 8; i++) begin
      e.cpu = (i % 2) == 1; e.rd = 1'b0; e.data = 16'h0000; e.due = t0 + 2 + 3 * i; sb1.push_back(e);
    end
    while ((kl < 4 || kc < 4) && n < 60) begin
      @(negedge clk); n++;
      if (b1.ldr_ack) begin
        kl++;
        if (kl == 4) b1.ldr_req = 1'b0;
        else begin
          b1.ldr_addr  = 12'h100 + 12'(kl);
          b1.ldr_wdata = 16'hB000 + 16'(kl);
        end
      end
      if (b1.cpu_ack) begin
        kc++;
        if (kc == 4) b1.cpu_req = 1'b0;
        else begin
          b1.cpu_addr  = 12'h200 + 12'(kc);
          b1.cpu_wdata = 16'hD000 + 16'(kc);
        end
      end
    end
    checks++;
    if (kl != 4 || kc != 4) begin
      errors++;
      $display("[TB] FAIL rr_timeout ldr_acks=%0d cpu_acks=%0d expected 4 and 4", kl, kc);
    end
    b1.ldr_req = 1'b0; b1.cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram1[12'h100 + i] !== 16'hB000 + 16'(i) || ram1[12'h200 + i] !== 16'hD000 + 16'(i)) begin
        errors++;
        $display("[TB] FAIL rr_ram idx=%0d ldr=%h cpu=%h expected %h %h", i, ram1[12'h100 + i],
                 ram1[12'h200 + i], 16'hB000 + 16'(i), 16'hD000 + 16'(i));
      end
    end
  endtask

  task automatic test_rd_lat3();
    exp_t e;
    int   n;
    @(negedge clk);
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 12'h020;
    e.cpu = 1'b1; e.rd = 1'b1; e.data = 16'h1234; e.due = ncyc + 5; sb3.push_back(e);
    n = 0;
    while (b3.cpu_ack !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (b3.cpu_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lat3_cpu_timeout cpu_ack=%b expected 1", b3.cpu_ack);
    end
    b3.cpu_req = 1'b0;

    @(negedge clk);
    b3.ldr_req = 1'b1; b3.ldr_we = 1'b0; b3.ldr_addr = 12'h7FF;
    e.cpu = 1'b0; e.rd = 1'b1; e.data = 16'hA5C3; e.due = ncyc + 5; sb3.push_back(e);
    n = 0;
    while (b3.ldr_ack !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (b3.ldr_ack !== 1'b1 || b3.cpu_rdata !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL lat3_ldr ldr_ack=%b cpu_rdata=%h expected 1 and 1234", b3.ldr_ack, b3.cpu_rdata);
    end
    b3.ldr_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    @(negedge clk);
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 12'h020;
    @(negedge clk);
    checks++;
    if (b1.mem_en !== 1'b1 || b1.mem_we !== 1'b0 || b1.mem_addr !== 12'h020) begin
      errors++;
      $display("[TB] FAIL mid_issue mem_en=%b mem_we=%b mem_addr=%h expected 1 0 020", b1.mem_en, b1.mem_we, b1.mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    b1.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.cpu_ack !== 1'b0 || b1.mem_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset cpu_ack=%b mem_en=%b expected 0 0", b1.cpu_ack, b1.mem_en);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (b1.cpu_ack !== 1'b0 || b1.mem_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_quiet cpu_ack=%b mem_en=%b expected 0 0", b1.cpu_ack, b1.mem_en);
      end
    end
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 12'h020;
    e.cpu = 1'b1; e.rd = 1'b1; e.data = 16'h7800; e.due = ncyc + 3; sb1.push_back(e);
    n = 0;
    while (b1.cpu_ack !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
    end
    checks++;
    if (b1.cpu_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reissue_timeout cpu_ack=%b expected 1", b1.cpu_ack);
    end
    b1.cpu_req = 1'b0;
  endtask

  initial begin
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.ldr_req = 1'b0; b1.ldr_we = 1'b0; b1.ldr_addr = '0; b1.ldr_wdata = '0;
    b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.ldr_req = 1'b0; b3.ldr_we = 1'b0; b3.ldr_addr = '0; b3.ldr_wdata = '0;
    $display("[TB] start");
    test_reset();
    test_cpu_write_read();
`ifdef MEM_ARB_RR_EN
    test_round_robin();
`else
    test_loader_burst();
`endif
    test_rd_lat3();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb1.size() != 0 || sb3.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain pending1=%0d pending3=%0d expected 0 0", sb1.size(), sb3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
